// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler: state encoding, requester IDs, lamp decode.
package traffic_pkg;

  localparam logic [2:0] ST_ALL_RED  = 3'd0;
  localparam logic [2:0] ST_NS_G     = 3'd1;
  localparam logic [2:0] ST_NS_Y     = 3'd2;
  localparam logic [2:0] ST_EW_G     = 3'd3;
  localparam logic [2:0] ST_EW_Y     = 3'd4;
  localparam logic [2:0] ST_PED_WALK = 3'd5;

  typedef enum logic [2:0] {
    S_ALL_RED  = ST_ALL_RED,
    S_NS_G     = ST_NS_G,
    S_NS_Y     = ST_NS_Y,
    S_EW_G     = ST_EW_G,
    S_EW_Y     = ST_EW_Y,
    S_PED_WALK = ST_PED_WALK
  } state_e;

  localparam logic [1:0] REQ_NS  = 2'd0;
  localparam logic [1:0] REQ_EW  = 2'd1;
  localparam logic [1:0] REQ_PED = 2'd2;

  typedef struct packed {
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    logic walk;
  } lamps_t;

  function automatic lamps_t lamp_decode(input logic [2:0] st);
    lamps_t l;
    l      = '0;
    l.ns_r = 1'b1;
    l.ew_r = 1'b1;
    case (st)
      ST_NS_G:     begin l.ns_g = 1'b1; l.ns_r = 1'b0; end
      ST_NS_Y:     begin l.ns_y = 1'b1; l.ns_r = 1'b0; end
      ST_EW_G:     begin l.ew_g = 1'b1; l.ew_r = 1'b0; end
      ST_EW_Y:     begin l.ew_y = 1'b1; l.ew_r = 1'b0; end
      ST_PED_WALK: l.walk = 1'b1;
      default:     ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter; search starts just after the last served requester.
module rr_arbiter3
  import traffic_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o,
  output logic       vld_o
);

  always_comb begin
    gnt_o = 3'b000;
    vld_o = |req_i;
    case (last_i)
      REQ_NS: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      REQ_EW: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven four-way intersection scheduler: NS / EW vehicles and a pedestrian walk,
// with min/max green, gap-out, yellow and all-red clearance. All durations count tick strobes.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ns_req,
  input  logic ew_req,
  input  logic ped_req,
  output logic ns_g,
  output logic ns_y,
  output logic ns_r,
  output logic ew_g,
  output logic ew_y,
  output logic ew_r,
  output logic walk,
  output logic ped_ack
);

  localparam int M1   = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
  localparam int M2   = (M1 > YELLOW) ? M1 : YELLOW;
  localparam int M3   = (M2 > ALL_RED) ? M2 : ALL_RED;
  localparam int MAXP = (M3 > WALK) ? M3 : WALK;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] Y_M1    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_M1 = CW'(WALK - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;
  logic          ped_pend_q, ped_pend_d;
  lamps_t        lamps_q;
  logic          ped_ack_q;

  logic [2:0]    arb_gnt;
  logic          arb_vld;
  logic          green;
  logic          enter_walk;

  rr_arbiter3 u_arb (
    .req_i  ({ped_pend_q, ew_req, ns_req}),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_ALL_RED: begin
        if (tick && cnt_q == AR_M1) begin
          if (arb_vld && arb_gnt[1]) begin
            state_d = S_EW_G;
            last_d  = REQ_EW;
          end else if (arb_vld && arb_gnt[2]) begin
            state_d = S_PED_WALK;
            last_d  = REQ_PED;
          end else begin
            // NS grant and the idle "home" case both land in NS_G
            state_d = S_NS_G;
            last_d  = REQ_NS;
          end
        end
      end
      S_NS_G: begin
        if (tick && (ew_req || ped_pend_q) &&
            ((cnt_q >= MIN_M1 && !ns_req) || cnt_q == MAX_M1))
          state_d = S_NS_Y;
      end
      S_EW_G: begin
        if (tick && (ns_req || ped_pend_q) &&
            ((cnt_q >= MIN_M1 && !ew_req) || cnt_q == MAX_M1))
          state_d = S_EW_Y;
      end
      S_NS_Y, S_EW_Y: begin
        if (tick && cnt_q == Y_M1) state_d = S_ALL_RED;
      end
      S_PED_WALK: begin
        if (tick && cnt_q == WALK_M1) state_d = S_ALL_RED;
      end
      default: state_d = S_ALL_RED;
    endcase

    green      = (state_q == S_NS_G) || (state_q == S_EW_G);
    enter_walk = (state_d == S_PED_WALK) && (state_q != S_PED_WALK);
    ped_pend_d = enter_walk ? 1'b0 : (ped_pend_q | ped_req);

    // Resting green holds cnt at MAX_GREEN-1 so a later competitor maxes out at once
    if (state_d != state_q)                    cnt_d = '0;
    else if (tick && !(green && cnt_q == MAX_M1)) cnt_d = cnt_q + 1'b1;
    else                                       cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ALL_RED;
      cnt_q      <= '0;
      last_q     <= REQ_EW;
      ped_pend_q <= 1'b0;
      lamps_q    <= lamp_decode(ST_ALL_RED);
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ped_pend_q <= ped_pend_d;
      lamps_q    <= lamp_decode(state_d);
      ped_ack_q  <= enter_walk;
    end
  end

  assign ns_g    = lamps_q.ns_g;
  assign ns_y    = lamps_q.ns_y;
  assign ns_r    = lamps_q.ns_r;
  assign ew_g    = lamps_q.ew_g;
  assign ew_y    = lamps_q.ew_y;
  assign ew_r    = lamps_q.ew_r;
  assign walk    = lamps_q.walk;
  assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios plus random traffic against a phase-level model.
module tb_intersection_scheduler;

  localparam int T_MIN  = 2;
  localparam int T_MAX  = 4;
  localparam int T_Y    = 1;
  localparam int T_AR   = 1;
  localparam int T_WALK = 2;

  localparam int P_AR  = 0;
  localparam int P_NSG = 1;
  localparam int P_NSY = 2;
  localparam int P_EWG = 3;
  localparam int P_EWY = 4;
  localparam int P_PW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic ns_req = 1'b0;
  logic ew_req = 1'b0;
  logic ped_req = 1'b0;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack;

  intersection_scheduler #(
    .MIN_GREEN (T_MIN),
    .MAX_GREEN (T_MAX),
    .YELLOW    (T_Y),
    .ALL_RED   (T_AR),
    .WALK      (T_WALK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ns_req  (ns_req),
    .ew_req  (ew_req),
    .ped_req (ped_req),
    .ns_g    (ns_g),
    .ns_y    (ns_y),
    .ns_r    (ns_r),
    .ew_g    (ew_g),
    .ew_y    (ew_y),
    .ew_r    (ew_r),
    .walk    (walk),
    .ped_ack (ped_ack)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    tc = 0;
  int    cyc = 0;
  string scen = "init";

  // phase-level reference: current phase, ticks spent in it, last served, pedestrian memory
  int mph = P_AR;
  int mel = 0;
  int mlast = 1;
  bit mpp = 1'b0;
  bit mack = 1'b0;

  int acks = 0;
  int gn_ticks = 0;

  function automatic logic [6:0] exp_lamps(input int ph);
    logic ng, ny, eg, ey, w;
    ng = (ph == P_NSG);
    ny = (ph == P_NSY);
    eg = (ph == P_EWG);
    ey = (ph == P_EWY);
    w  = (ph == P_PW);
    return {ng, ny, !(ng || ny), eg, ey, !(eg || ey), w};
  endfunction

  function automatic bit tick_next();
    return (tc % 4) == 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s cyc=%0d got=%0h exp=%0h", scen, tag, cyc, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit tk, input bit n, input bit e, input bit p);
    int nxt;
    int done;
    bit found;
    if (r) begin
      mph = P_AR; mel = 0; mlast = 1; mpp = 1'b0; mack = 1'b0;
    end else begin
      nxt = mph;
      if (tk) begin
        done = mel + 1;
        case (mph)
          P_AR: if (done >= T_AR) begin
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
              int c;
              bit pend;
              c = (mlast + k) % 3;
              pend = (c == 0) ? n : (c == 1) ? e : mpp;
              if (!found && pend) begin
                found = 1'b1;
                mlast = c;
                nxt = (c == 0) ? P_NSG : (c == 1) ? P_EWG : P_PW;
              end
            end
            if (!found) begin
              nxt = P_NSG;
              mlast = 0;
            end
          end
          P_NSG: if ((e || mpp) && ((done >= T_MIN && !n) || done >= T_MAX)) nxt = P_NSY;
          P_EWG: if ((n || mpp) && ((done >= T_MIN && !e) || done >= T_MAX)) nxt = P_EWY;
          P_NSY, P_EWY: if (done >= T_Y) nxt = P_AR;
          P_PW: if (done >= T_WALK) nxt = P_AR;
          default: nxt = P_AR;
        endcase
      end
      if (nxt != mph) mel = 0;
      else if (tk) mel = mel + 1;
      mack = (nxt == P_PW) && (mph != P_PW);
      mpp  = mack ? 1'b0 : (mpp | p);
      mph  = nxt;
    end
  endtask

  task automatic step(input bit r, input bit n, input bit e, input bit p);
    bit tk;
    tk = tick_next();
    rst = r; tick = tk; ns_req = n; ew_req = e; ped_req = p;
    if (tk && !r && ns_g) gn_ticks++;
    @(posedge clk);
    model(r, tk, n, e, p);
    tc++;
    cyc++;
    #1;
    chk("lamps", {25'd0, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}, {25'd0, exp_lamps(mph)});
    chk("ack", {31'd0, ped_ack}, {31'd0, mack});
    if (ped_ack) acks++;
  endtask

  initial begin
    bit n, e, p, r, ent_done, mid_done, got_g, seen;

    // Idle: home to NS_G and rest there for 20+ ticks
    scen = "idle";
    step(1, 0, 0, 0);
    for (int i = 0; i < 88; i++) step(0, 0, 0, 0);
    chk("idle_ns_g", {31'd0, ns_g}, 32'd1);
    chk("idle_walk", {31'd0, walk}, 32'd0);

    // Both vehicles pending: alternate by max-out
    scen = "maxout";
    step(1, 1, 1, 0);
    for (int i = 0; i < 110; i++) step(0, 1, 1, 0);

    // Gap-out after MIN_GREEN when EW arrives during NS green
    scen = "gapout";
    step(1, 0, 0, 0);
    got_g = 1'b0;
    for (int i = 0; i < 20 && !got_g; i++) begin
      step(0, 0, 0, 0);
      got_g = ns_g;
    end
    chk("gap_reach_ns_g", {31'd0, got_g}, 32'd1);
    gn_ticks = 0;
    seen = 1'b0;
    while (!seen) begin
      seen = tick_next();
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
    chk("gap_green_ticks", gn_ticks, 32'd2);
    chk("gap_ew_g", {31'd0, ew_g}, 32'd1);

    // Pedestrian during NS green with EW waiting: EW first, then one walk
    scen = "ped1";
    step(1, 0, 1, 0);
    acks = 0;
    got_g = 1'b0;
    for (int i = 0; i < 20 && !got_g; i++) begin
      step(0, 0, 1, 0);
      got_g = ns_g;
    end
    step(0, 0, 1, 1);
    for (int i = 0; i < 90; i++) step(0, 0, 1, 0);
    chk("ped1_acks", acks, 32'd1);

    // Pulse on the walk-entry edge is absorbed; mid-walk pulse yields one more walk
    scen = "ped2";
    step(1, 0, 1, 0);
    acks = 0;
    got_g = 1'b0;
    for (int i = 0; i < 20 && !got_g; i++) begin
      step(0, 0, 1, 0);
      got_g = ns_g;
    end
    step(0, 0, 1, 1);
    ent_done = 1'b0;
    mid_done = 1'b0;
    for (int i = 0; i < 140; i++) begin
      p = 1'b0;
      if (!ent_done && mph == P_AR && mlast == 1 && mpp && tick_next()) begin
        p = 1'b1;
        ent_done = 1'b1;
      end else if (ent_done && !mid_done && mph == P_PW && !mack) begin
        p = 1'b1;
        mid_done = 1'b1;
      end
      step(0, 0, 1, p);
    end
    chk("ped2_pulses_applied", {30'd0, ent_done, mid_done}, 32'd3);
    chk("ped2_acks", acks, 32'd2);

    // Reset in the middle of EW yellow
    scen = "rst_mid";
    step(1, 1, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(0, 1, 1, 0);
      seen = ew_y;
    end
    chk("rst_reach_ew_y", {31'd0, seen}, 32'd1);
    step(1, 1, 1, 0);
    chk("rst_lamps", {24'd0, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack}, 32'b00100100);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    chk("rst_then_ns_g", {31'd0, ns_g}, 32'd1);

    // Random traffic
    scen = "random";
    n = 1'b0; e = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) n = ~n;
      if ($urandom_range(15) == 0) e = ~e;
      p = ($urandom_range(19) == 0);
      r = ($urandom_range(299) == 0);
      step(r, n, e, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
